// File: rtl/vc_rr_switch_if.sv
`default_nettype none
// ============================================================================
// Module   : vc_rr_switch_if
// Purpose  : VC input bundle plus output link of the round-robin VC switch.
// Revision : 1.0
// ============================================================================
interface vc_rr_switch_if #(
  parameter int NUM_VC = 4,
  parameter int DATA_W = 8
);
  localparam int VC_IDX_W = $clog2(NUM_VC);

  logic [NUM_VC*DATA_W-1:0] vc_data;
  logic [NUM_VC-1:0]        vc_valid;
  logic [NUM_VC-1:0]        vc_last;
  logic [NUM_VC-1:0]        vc_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [VC_IDX_W-1:0]      out_vc;
  logic                     out_ready;

  // The switch sits on the slave side; the VC buffers / link drive the master side.
  modport slave (
    input  vc_data, vc_valid, vc_last, out_ready,
    output vc_ready, out_data, out_valid, out_last, out_vc
  );

  modport master (
    output vc_data, vc_valid, vc_last, out_ready,
    input  vc_ready, out_data, out_valid, out_last, out_vc
  );
endinterface
`default_nettype wire

// File: rtl/vc_rr_switch.sv
`default_nettype none
// ============================================================================
// Module   : vc_rr_switch
// Purpose  : Round-robin merge of NUM_VC virtual channels onto one registered
//            output link, with optional head-to-tail packet lock.
// Revision : 1.0
// ============================================================================
module vc_rr_switch #(
  parameter int NUM_VC   = 4,
  parameter int DATA_W   = 8,
  parameter int PKT_MODE = 0
) (
  input  wire              clk,
  input  wire              reset_n,
  vc_rr_switch_if.slave    bus
);
  localparam int VC_IDX_W = $clog2(NUM_VC);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_st_t;

  lock_st_t              r_state;
  lock_st_t              w_state_nxt;
  logic [VC_IDX_W-1:0]   r_lock_vc;
  logic [VC_IDX_W-1:0]   w_lock_vc_nxt;
  logic [VC_IDX_W-1:0]   r_ptr;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [VC_IDX_W-1:0]   r_out_vc;

  logic                  w_load;
  logic [NUM_VC-1:0]     w_lock_mask;
  logic [NUM_VC-1:0]     w_elig;
  logic                  w_found;
  logic [VC_IDX_W-1:0]   w_win;
  logic                  w_accept;
  logic [NUM_VC-1:0]     w_ready;
  logic                  w_win_last;

  assign w_load = !r_out_valid || bus.out_ready;

  always_comb begin
    w_lock_mask = '0;
    w_lock_mask[r_lock_vc] = 1'b1;
    w_elig = bus.vc_valid;
    if (r_state == ST_LOCKED) begin
      w_elig = bus.vc_valid & w_lock_mask;
    end
  end

  // Search starts one past the last winner and wraps, so the last winner is lowest priority.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = (int'(r_ptr) + i) % NUM_VC;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = idx[VC_IDX_W-1:0];
      end
    end
  end

  assign w_accept   = reset_n && w_found && w_load;
  assign w_win_last = bus.vc_last[w_win];

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_win] = 1'b1;
    end
  end

  assign bus.vc_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_vc    = r_out_vc;

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_vc_nxt = r_lock_vc;
    if (PKT_MODE != 0 && w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_win_last) begin
            w_state_nxt   = ST_LOCKED;
            w_lock_vc_nxt = w_win;
          end
        end
        ST_LOCKED: begin
          if (w_win_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_lock_vc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_vc <= w_lock_vc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr       <= VC_IDX_W'(NUM_VC - 1);
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_vc    <= '0;
    end else if (w_load) begin
      r_out_valid <= w_found;
      if (w_found) begin
        r_out_data <= bus.vc_data[int'(w_win)*DATA_W +: DATA_W];
        r_out_last <= w_win_last;
        r_out_vc   <= w_win;
        r_ptr      <= w_win;
      end
    end
  end
endmodule
`default_nettype wire
